// File: rtl/throughout_burst_sched.sv
// Round-robin burst scheduler: grants one of two requesters an a/b burst of len beats,
// then closes it with a c (done) or abrt pulse followed by GAP idle cycles.
module throughout_burst_sched #(
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             abort,
  output logic             gnt0,
  output logic             gnt1,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             abrt,
  output logic             busy,
  output logic             owner,
  output logic [LEN_W-1:0] beat_cnt,
  output logic [1:0]       state_dbg
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] rem, rem_d;
  logic [LEN_W-1:0] cnt_d;
  logic [GW-1:0]    gap_cnt, gap_d;
  logic             pri, pri_d;
  logic             owner_d, gnt0_d, gnt1_d, c_d, abrt_d;
  logic             win;
  logic [LEN_W-1:0] win_len;

  // Handshake: req0/req1 are levels held until the matching one-cycle gnt pulse;
  // a request that drops before its grant is forgotten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rem      <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      pri      <= 1'b0;
      owner    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      c        <= 1'b0;
      abrt     <= 1'b0;
    end else begin
      state    <= state_d;
      rem      <= rem_d;
      beat_cnt <= cnt_d;
      gap_cnt  <= gap_d;
      pri      <= pri_d;
      owner    <= owner_d;
      gnt0     <= gnt0_d;
      gnt1     <= gnt1_d;
      c        <= c_d;
      abrt     <= abrt_d;
    end
  end

  always_comb begin
    state_d = state;
    rem_d   = rem;
    cnt_d   = beat_cnt;
    gap_d   = gap_cnt;
    pri_d   = pri;
    owner_d = owner;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    c_d     = 1'b0;
    abrt_d  = 1'b0;
    win     = 1'b0;
    win_len = len0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // pri names the requester that was not granted last.
          win     = (req0 && req1) ? pri : req1;
          win_len = win ? len1 : len0;
          rem_d   = (win_len == '0) ? '0 : win_len - LEN_W'(1);
          cnt_d   = LEN_W'(1);
          owner_d = win;
          pri_d   = ~win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (abort) begin
          abrt_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (rem == '0) begin
          c_d     = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          rem_d = rem - LEN_W'(1);
          cnt_d = beat_cnt + LEN_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decodes of the state register, so still free of input-to-output paths.
  assign a         = (state == S_BURST);
  assign b         = (state == S_BURST);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_throughout_burst_sched.sv
// Directed bench for throughout_burst_sched: hand-computed per-cycle expectations
// for grant, burst window, done/abort pulses, round-robin order and async reset.
module tb_throughout_burst_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, abort = 1'b0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic       gnt0, gnt1, a, b, c, abrt, busy, owner;
  logic [3:0] beat_cnt;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  throughout_burst_sched #(.LEN_W(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .abort(abort), .gnt0(gnt0), .gnt1(gnt1), .a(a), .b(b), .c(c), .abrt(abrt),
    .busy(busy), .owner(owner), .beat_cnt(beat_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Bit order: gnt0 gnt1 a b c abrt busy owner
  function automatic logic [7:0] outs();
    return {gnt0, gnt1, a, b, c, abrt, busy, owner};
  endfunction

  function automatic logic [7:0] beat_bits(input logic first, input logic own);
    return {first & ~own, first & own, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, own};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_cycle(input string tag, input logic [7:0] eb, input logic [3:0] ec);
    check({tag, "/outs"}, 32'(outs()), 32'(eb));
    check({tag, "/cnt"}, 32'(beat_cnt), 32'(ec));
  endtask

  initial begin
    // Reset
    tick();
    tick();
    expect_cycle("reset", 8'b0000_0000, 4'd0);
    check("reset/state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // req0 alone, len0=3
    req0 = 1'b1; len0 = 4'd3;
    tick(); expect_cycle("t1_b1", beat_bits(1'b1, 1'b0), 4'd1);
    req0 = 1'b0;
    tick(); expect_cycle("t1_b2", beat_bits(1'b0, 1'b0), 4'd2);
    tick(); expect_cycle("t1_b3", beat_bits(1'b0, 1'b0), 4'd3);
    tick(); expect_cycle("t1_done", 8'b0000_1010, 4'd3);
    tick(); expect_cycle("t1_idle", 8'b0000_0000, 4'd0);

    // req1 alone, len1=0 -> one beat
    req1 = 1'b1; len1 = 4'd0;
    tick(); expect_cycle("t3_b1", beat_bits(1'b1, 1'b1), 4'd1);
    req1 = 1'b0;
    tick(); expect_cycle("t3_done", 8'b0000_1011, 4'd1);
    tick(); expect_cycle("t3_idle", 8'b0000_0001, 4'd0);

    // abort outside BURST is ignored
    abort = 1'b1;
    tick(); expect_cycle("idle_abort", 8'b0000_0001, 4'd0);
    abort = 1'b0;

    // both requests held, alternating grants 0,1,0,1
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd4;
    for (int k = 0; k < 4; k++) begin
      logic w;
      int   l;
      w = k[0];
      l = w ? 4 : 2;
      for (int i = 1; i <= l; i++) begin
        tick();
        expect_cycle($sformatf("t2_k%0d_b%0d", k, i), beat_bits(i == 1, w), 4'(i));
      end
      tick(); expect_cycle($sformatf("t2_k%0d_done", k), {7'b0000_101, w}, 4'(l));
      tick(); expect_cycle($sformatf("t2_k%0d_idle", k), {7'b0000_000, w}, 4'd0);
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end

    // len0=15 aborted during beat 5
    req0 = 1'b1; len0 = 4'd15;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_cycle($sformatf("t4_b%0d", i), beat_bits(i == 1, 1'b0), 4'(i));
      req0 = 1'b0;
    end
    abort = 1'b1;
    tick(); expect_cycle("t4_abrt", 8'b0000_0110, 4'd5);
    abort = 1'b0;
    tick(); expect_cycle("t4_idle", 8'b0000_0000, 4'd0);

    // abort on the last beat of a len=3 burst wins over done
    req0 = 1'b1; len0 = 4'd3;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_cycle($sformatf("t5_b%0d", i), beat_bits(i == 1, 1'b0), 4'(i));
      req0 = 1'b0;
    end
    abort = 1'b1;
    tick(); expect_cycle("t5_abrt", 8'b0000_0110, 4'd3);
    abort = 1'b0;
    tick(); expect_cycle("t5_idle", 8'b0000_0000, 4'd0);

    // async reset at beat 2 of 6, release with req1 pending
    req0 = 1'b1; len0 = 4'd6;
    tick(); expect_cycle("t6_b1", beat_bits(1'b1, 1'b0), 4'd1);
    req0 = 1'b0;
    tick(); expect_cycle("t6_b2", beat_bits(1'b0, 1'b0), 4'd2);
    rst = 1'b1;
    #1;
    expect_cycle("t6_rst_now", 8'b0000_0000, 4'd0);
    check("t6_rst_state", 32'(state_dbg), 32'd0);
    req1 = 1'b1; len1 = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_cycle($sformatf("t6_rst_%0d", i), 8'b0000_0000, 4'd0);
    end
    rst = 1'b0;
    tick(); expect_cycle("t6_b1_after", beat_bits(1'b1, 1'b1), 4'd1);
    req1 = 1'b0;
    tick(); expect_cycle("t6_b2_after", beat_bits(1'b0, 1'b1), 4'd2);
    tick(); expect_cycle("t6_done", 8'b0000_1011, 4'd2);
    tick(); expect_cycle("t6_idle", 8'b0000_0001, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
